// File: rtl/int_pkg.sv
// Shared types and default configuration for the interrupt controller slice.
package int_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    localparam int          DEF_NUM_IRQ    = 4;
    localparam int          DEF_PC_W       = 10;
    localparam int unsigned DEF_VEC_BASE   = 32'h3C0;
    localparam int unsigned DEF_VEC_STRIDE = 4;

    // Full-width vector address; callers truncate to their PC width (modulo 2^PC_W).
    function automatic logic [31:0] vec_of(input int unsigned id,
                                           input int unsigned base   = DEF_VEC_BASE,
                                           input int unsigned stride = DEF_VEC_STRIDE);
        return 32'(base + id * stride);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-index priority encoder: index 0 wins, valid flags a non-empty input.
module irq_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   vec,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    logic [N:0]   lower;
    logic [N-1:0] first;

    assign lower[0] = 1'b0;

    // lower[i] is set when any bit below i is set, so first[] is one-hot.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chain
            assign lower[gi+1] = lower[gi] | vec[gi];
            assign first[gi]   = vec[gi] & ~lower[gi];
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (first[i]) begin
                idx = idx | IDW'(i);
            end
        end
    end

    assign valid = lower[N];

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller and return-stack command arbiter for the single-cycle CPU.
// Define INT_NEST_EN to let a higher-priority request preempt a running ISR.
module interrupt_ctrl
    import int_pkg::*;
#(
    parameter int          NUM_IRQ    = DEF_NUM_IRQ,
    parameter int          PC_W       = DEF_PC_W,
    parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
    parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [PC_W-1:0]    pc,
    input  logic               call,
    input  logic               ret,
    input  logic               reti,
    input  logic               ei,
    input  logic               di,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               stack_ovf,
    output logic               take_int,
    output logic [PC_W-1:0]    vector,
    output logic               stack_push,
    output logic               stack_pop,
    output logic               stack_int,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic               gie
);

    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_q_reg;
    logic               armed_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] mask_reg, mask_next;
    logic [NUM_IRQ-1:0] in_service_reg, in_service_next;
    logic               gie_reg, gie_next;
    state_t             state_reg, state_next;

    logic [NUM_IRQ-1:0] cand;
    logic [IDW-1:0]     cand_id, svc_id;
    logic               cand_valid, svc_valid;
    logic               permit;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] take_vec;
    logic [NUM_IRQ-1:0] svc_after_reti;
    logic               reti_in_service;
    logic               unused_ok;

    assign cand = pending_reg & mask_reg;

    irq_prio_enc #(.N(NUM_IRQ), .IDW(IDW)) u_cand_enc (
        .vec   (cand),
        .idx   (cand_id),
        .valid (cand_valid)
    );

    irq_prio_enc #(.N(NUM_IRQ), .IDW(IDW)) u_svc_enc (
        .vec   (in_service_reg),
        .idx   (svc_id),
        .valid (svc_valid)
    );

`ifdef INT_NEST_EN
    assign permit    = (state_reg == IDLE) || (svc_valid && (cand_id < svc_id));
    assign unused_ok = ^pc;
`else
    assign permit    = (state_reg == IDLE);
    assign unused_ok = ^{pc, svc_id, svc_valid};
`endif

    assign take_int = gie_reg & cand_valid & ~reti & ~stack_ovf & permit;
    assign vector   = take_int ? PC_W'(vec_of(32'(cand_id), VEC_BASE, VEC_STRIDE)) : '0;

    // The preempted instruction's pc is pushed; a coinciding call/ret is killed and replays later.
    assign stack_push = take_int | call;
    assign stack_pop  = (ret | reti) & ~take_int;
    assign stack_int  = reti;

    // The first cycle after reset only captures the irq level, so held lines never look like edges.
    assign rise            = armed_reg ? (irq & ~irq_q_reg) : '0;
    assign take_vec        = take_int ? (NUM_IRQ'(1) << cand_id) : '0;
    assign svc_after_reti  = in_service_reg & (in_service_reg - NUM_IRQ'(1));
    assign reti_in_service = reti && (state_reg == SERVICE);

    always_comb begin
        pending_next    = (pending_reg & ~take_vec) | rise;
        mask_next       = mask_we ? mask_wdata : mask_reg;
        in_service_next = in_service_reg;
        state_next      = state_reg;
        gie_next        = gie_reg;
        if (take_int) begin
            in_service_next = in_service_reg | take_vec;
            state_next      = SERVICE;
            gie_next        = 1'b0;
        end else begin
            if (reti_in_service) begin
                in_service_next = svc_after_reti;
                if (svc_after_reti == '0) begin
                    state_next = IDLE;
                end
            end
            if (reti_in_service && (svc_after_reti == '0)) begin
                gie_next = 1'b1;
            end else if (di) begin
                gie_next = 1'b0;
            end else if (ei) begin
                gie_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q_reg      <= '0;
            armed_reg      <= 1'b0;
            pending_reg    <= '0;
            mask_reg       <= '0;
            in_service_reg <= '0;
            gie_reg        <= 1'b0;
            state_reg      <= IDLE;
        end else begin
            irq_q_reg      <= irq;
            armed_reg      <= 1'b1;
            pending_reg    <= pending_next;
            mask_reg       <= mask_next;
            in_service_reg <= in_service_next;
            gie_reg        <= gie_next;
            state_reg      <= state_next;
        end
    end

    assign in_service = in_service_reg;
    assign pending    = pending_reg;
    assign gie        = gie_reg;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios then random traffic vs a queue-based model.
module tb_interrupt_ctrl;

`ifdef INT_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic [9:0] pc;
    logic       call, ret, reti, ei, di, mask_we, stack_ovf;
    logic [3:0] mask_wdata;
    logic       take_int, stack_push, stack_pop, stack_int, gie;
    logic [9:0] vector;
    logic [3:0] in_service, pending;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: serviced ids kept as a list, flags as plain bits.
    bit [3:0] m_pending, m_mask, m_irq_prev;
    bit       m_gie, m_armed;
    int       svc_q[$];

    always #5 clk = ~clk;

    interrupt_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .pc         (pc),
        .call       (call),
        .ret        (ret),
        .reti       (reti),
        .ei         (ei),
        .di         (di),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .stack_ovf  (stack_ovf),
        .take_int   (take_int),
        .vector     (vector),
        .stack_push (stack_push),
        .stack_pop  (stack_pop),
        .stack_int  (stack_int),
        .in_service (in_service),
        .pending    (pending),
        .gie        (gie)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        call = 0; ret = 0; reti = 0; ei = 0; di = 0;
        mask_we = 0; mask_wdata = 0; stack_ovf = 0; reset = 0;
    endtask

    // One clock: check every output against the model mid-cycle, then advance the model.
    task automatic step();
        bit [3:0] cand, svc_vec, rise;
        bit       has, exp_take, done;
        int       cid, min_svc, min_k;
        @(negedge clk);
        cand = m_pending & m_mask;
        has = 0; cid = 0;
        for (int i = 3; i >= 0; i--) if (cand[i]) begin has = 1; cid = i; end
        svc_vec = 0; min_svc = 4; min_k = 0;
        foreach (svc_q[k]) begin
            svc_vec[svc_q[k]] = 1'b1;
            if (svc_q[k] < min_svc) begin min_svc = svc_q[k]; min_k = k; end
        end
        exp_take = m_gie && has && !reti && !stack_ovf
                   && (svc_q.size() == 0 || (NEST && cid < min_svc));
        chk("take_int", 32'(take_int), 32'(exp_take));
        if (exp_take) chk("vector", 32'(vector), (32'h3C0 + 32'(cid) * 4) % 1024);
        chk("stack_push", 32'(stack_push), 32'(exp_take || call));
        chk("stack_pop", 32'(stack_pop), 32'((ret || reti) && !exp_take));
        chk("stack_int", 32'(stack_int), 32'(reti));
        chk("pending", 32'(pending), 32'(m_pending));
        chk("in_service", 32'(in_service), 32'(svc_vec));
        chk("gie", 32'(gie), 32'(m_gie));
        @(posedge clk);
        if (reset) begin
            m_pending = 0; m_mask = 0; m_irq_prev = 0; m_gie = 0; m_armed = 0;
            svc_q.delete();
        end else begin
            rise = m_armed ? (irq & ~m_irq_prev) : 4'b0;
            if (exp_take) begin
                m_pending[cid] = 1'b0;
                svc_q.push_back(cid);
                m_gie = 0;
            end else begin
                done = 0;
                if (reti && svc_q.size() > 0) begin
                    svc_q.delete(min_k);
                    if (svc_q.size() == 0) begin m_gie = 1; done = 1; end
                end
                if (!done) begin
                    if (di) m_gie = 0;
                    else if (ei) m_gie = 1;
                end
            end
            m_pending = m_pending | rise;
            if (mask_we) m_mask = mask_wdata;
            m_irq_prev = irq;
            m_armed = 1;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        irq = 0; pc = 0;
        m_pending = 0; m_mask = 0; m_irq_prev = 0; m_gie = 0; m_armed = 0;
        reset = 1;
        step(); step();
        chk("rst_take", 32'(take_int), 32'(0));
        chk("rst_gie", 32'(gie), 32'(0));
        reset = 0;

        // Enable everything, then a single edge on irq[2].
        mask_we = 1; mask_wdata = 4'b1111; ei = 1;
        step();
        clear_inputs();
        irq = 4'b0100; pc = 10'h012;
        step();
        chk("t1_pending", 32'(pending), 32'h4);
        chk("t1_take", 32'(take_int), 32'h1);
        chk("t1_vector", 32'(vector), 32'h3C8);
        chk("t1_push", 32'(stack_push), 32'h1);
        step();
        chk("t1_svc", 32'(in_service), 32'h4);
        chk("t1_pend_clr", 32'(pending), 32'h0);
        reti = 1; #1;
        chk("t1_reti_pop", 32'(stack_pop), 32'h1);
        step();
        reti = 0;
        chk("t1_gie_back", 32'(gie), 32'h1);
        irq = 0;
        step();

        // Simultaneous irq[3] and irq[1]: priority then back-to-back dispatch.
        irq = 4'b1010;
        step();
        chk("t2_vec1", 32'(vector), 32'h3C4);
        step();
        chk("t2_svc", 32'(in_service), 32'h2);
        chk("t2_pend", 32'(pending), 32'h8);
        reti = 1; #1;
        chk("t2_int", 32'(stack_int), 32'h1);
        step();
        reti = 0; #1;
        chk("t2_take3", 32'(take_int), 32'h1);
        chk("t2_vec3", 32'(vector), 32'h3CC);
        step();
        reti = 1; step(); reti = 0;
        irq = 0; step();

        // CALL coinciding with dispatch is suppressed into a single push.
        irq = 4'b0001;
        step();
        call = 1; pc = 10'h155; #1;
        chk("t3_take", 32'(take_int), 32'h1);
        chk("t3_push", 32'(stack_push), 32'h1);
        chk("t3_vec", 32'(vector), 32'h3C0);
        step();
        call = 0;
        reti = 1; #1;
        chk("t3_pop", 32'(stack_pop), 32'h1);
        chk("t3_nopush", 32'(stack_push), 32'h0);
        step();
        reti = 0; irq = 0; step();

        // Stack overflow holds requests pending.
        stack_ovf = 1; irq = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold", 32'(take_int), 32'h0);
        end
        chk("t4_pend", 32'(pending), 32'h1);
        stack_ovf = 0; #1;
        chk("t4_release", 32'(take_int), 32'h1);
        step();
        reti = 1; step(); reti = 0;
        irq = 0; step();

        // Reset in service with a pending request; held irq must not re-trigger.
        irq = 4'b0001; step(); step();
        irq = 4'b1001; step();
        chk("t5_pend", 32'(pending), 32'h8);
        reset = 1; step(); reset = 0; #1;
        chk("t5_pend0", 32'(pending), 32'h0);
        chk("t5_svc0", 32'(in_service), 32'h0);
        chk("t5_push0", 32'(stack_push), 32'h0);
        step(); step();
        chk("t5_noretrig", 32'(pending), 32'h0);
        irq = 0; mask_we = 1; mask_wdata = 4'b1111; ei = 1;
        step();
        clear_inputs();

`ifdef INT_NEST_EN
        // Nested preemption of IRQ 2 by IRQ 0.
        irq = 4'b0100; step(); step();
        ei = 1; step(); ei = 0;
        irq = 4'b0101; step();
        chk("t6_take", 32'(take_int), 32'h1);
        chk("t6_vec", 32'(vector), 32'h3C0);
        step();
        chk("t6_svc", 32'(in_service), 32'h5);
        reti = 1; step(); reti = 0;
        chk("t6_svc2", 32'(in_service), 32'h4);
        chk("t6_gie0", 32'(gie), 32'h0);
        reti = 1; step(); reti = 0;
        chk("t6_gie1", 32'(gie), 32'h1);
        irq = 0; step();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            reset = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            case ($urandom_range(0, 15))
                0: call = 1;
                1: ret = 1;
                2: reti = 1;
                default: ;
            endcase
            ei = ($urandom_range(0, 5) == 0);
            di = ($urandom_range(0, 11) == 0);
            mask_we = ($urandom_range(0, 19) == 0);
            mask_wdata = 4'($urandom);
            stack_ovf = ($urandom_range(0, 9) == 0);
            pc = 10'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
